// File: rtl/node_xfer_buf_pkg.sv
// Shared constants, word type and FSM state encoding for the node ordering transfer buffer.
package node_xfer_buf_pkg;

  localparam int unsigned LANES    = 8;
  localparam int unsigned LANE_W   = 8;
  localparam int unsigned NODE_NUM = 4;

  typedef logic [LANES-1:0][LANE_W-1:0] ord_word_t;

  typedef enum logic [1:0] {IDLE, WR, RD_WAIT, RD} xfer_state_t;

  // The top bit of every lane is a flag that must never cross the buffer.
  function automatic ord_word_t clear_flags(input ord_word_t w);
    ord_word_t r;
    r = w;
    for (int i = 0; i < LANES; i++) r[i][LANE_W-1] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/node_xfer_buf_if.sv
// Host bus and replica pipeline signal bundle for node_xfer_buf.
interface node_xfer_buf_if #(
  parameter int unsigned DEPTH = 16
);
  import node_xfer_buf_pkg::*;

  localparam int unsigned CntW = $clog2(DEPTH);

  logic [CntW-1:0] ord_num;
  logic            wr_req;
  ord_word_t       wdata;
  logic            rd_req;
  logic            out_valid;
  ord_word_t       out_data;
  logic            ready;
  logic            rvalid;
  ord_word_t       rdata;
  logic            reg_valid;
  ord_word_t       reg_data;
  logic            shift_first;
  logic            shift_last;
  logic            ovf;

  modport master (
    output ord_num, wr_req, wdata, rd_req, out_valid, out_data,
    input  ready, rvalid, rdata, reg_valid, reg_data, shift_first, shift_last, ovf
  );

  modport slave (
    input  ord_num, wr_req, wdata, rd_req, out_valid, out_data,
    output ready, rvalid, rdata, reg_valid, reg_data, shift_first, shift_last, ovf
  );

endinterface

// File: rtl/node_xfer_fifo.sv
// Read-path FIFO: first-word fall-through, flushable, drops pushes when full.
module node_xfer_fifo
  import node_xfer_buf_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      flush,
  input  logic      push,
  input  ord_word_t wdata,
  input  logic      pop,
  output ord_word_t rdata,
  output logic      empty,
  output logic      full,
  output logic      ovf_pulse
);

  localparam int unsigned AW = $clog2(DEPTH);

  ord_word_t     mem_q [DEPTH];
  logic [AW:0]   wptr_q, rptr_q;
  logic          do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // A pop frees the slot a simultaneous push needs, so full+pop+push still lands.
  assign do_pop    = pop && !empty && !flush;
  assign do_push   = push && !flush && (!full || do_pop);
  assign ovf_pulse = push && !flush && full && !do_pop;

  assign rdata = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/node_xfer_buf.sv
// Bidirectional node ordering-word transfer buffer with exchange-shift strobes.
// Define NODE_XFER_LANE_REV_EN to reverse lane order on host reads.
module node_xfer_buf
  import node_xfer_buf_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned WR_LAT = 3
) (
  input logic           clk,
  input logic           reset,
  node_xfer_buf_if.slave bus
);

  localparam int unsigned CntW  = $clog2(DEPTH);
  localparam int unsigned NodeW = (NODE_NUM > 1) ? $clog2(NODE_NUM) : 1;
  localparam logic [NodeW-1:0] LastNode = NodeW'(NODE_NUM - 1);

  xfer_state_t      state_q, state_d;
  logic [CntW-1:0]  cnt_q;
  logic [NodeW-1:0] node_q;
  logic             bubble_q;
  logic             shift_first_q, shift_last_q;
  logic             rvalid_q, ovf_q;
  ord_word_t        rdata_q;

  logic             ready, flush, wr_acc, rd_acc, beat, last_beat;
  logic             fifo_empty, fifo_ovf, unused_full;
  ord_word_t        fifo_rdata, host_word;

  logic [WR_LAT-1:0] dly_vld_q;
  ord_word_t         dly_data_q [WR_LAT];

  assign last_beat = (cnt_q == bus.ord_num);

  always_comb begin
    ready = 1'b0;
    unique case (state_q)
      IDLE, WR: ready = !bubble_q;
      RD:       ready = !fifo_empty;
      default:  ready = 1'b0;
    endcase
  end

  assign wr_acc = bus.wr_req && ready && (state_q inside {IDLE, WR});
  assign rd_acc = bus.rd_req && ready && (state_q == RD);
  assign beat   = wr_acc || rd_acc;

  always_comb begin
    state_d = state_q;
    flush   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A write request wins over a simultaneous read request.
        if (wr_acc) begin
          state_d = last_beat ? IDLE : WR;
        end else if (bus.rd_req) begin
          state_d = RD_WAIT;
          flush   = 1'b1;
        end
      end
      WR:      if (wr_acc && last_beat) state_d = IDLE;
      RD_WAIT: if (!fifo_empty || bus.out_valid) state_d = RD;
      RD:      if (rd_acc && last_beat) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      node_q        <= '0;
      bubble_q      <= 1'b0;
      shift_first_q <= 1'b0;
      shift_last_q  <= 1'b0;
      rvalid_q      <= 1'b0;
      rdata_q       <= '0;
      ovf_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      bubble_q      <= wr_acc && (cnt_q == '0);
      shift_first_q <= beat && (cnt_q == '0);
      shift_last_q  <= beat && last_beat && (node_q == LastNode);
      rvalid_q      <= rd_acc;
      ovf_q         <= ovf_q || fifo_ovf;
      if (rd_acc) rdata_q <= clear_flags(host_word);
      if (beat) begin
        if (last_beat) begin
          cnt_q  <= '0;
          node_q <= (node_q == LastNode) ? '0 : node_q + 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  // Non-stalling delay line; bubbles travel as zero words with valid low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dly_vld_q <= '0;
      for (int i = 0; i < WR_LAT; i++) dly_data_q[i] <= '0;
    end else begin
      dly_vld_q[0]  <= wr_acc;
      dly_data_q[0] <= wr_acc ? clear_flags(bus.wdata) : '0;
      for (int i = 1; i < WR_LAT; i++) begin
        dly_vld_q[i]  <= dly_vld_q[i-1];
        dly_data_q[i] <= dly_data_q[i-1];
      end
    end
  end

  node_xfer_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (bus.out_valid),
    .wdata     (bus.out_data),
    .pop       (rd_acc),
    .rdata     (fifo_rdata),
    .empty     (fifo_empty),
    .full      (unused_full),
    .ovf_pulse (fifo_ovf)
  );

`ifdef NODE_XFER_LANE_REV_EN
  always_comb begin
    for (int i = 0; i < LANES; i++) host_word[i] = fifo_rdata[LANES-1-i];
  end
`else
  assign host_word = fifo_rdata;
`endif

  assign bus.ready       = ready;
  assign bus.rvalid      = rvalid_q;
  assign bus.rdata       = rdata_q;
  assign bus.reg_valid   = dly_vld_q[WR_LAT-1];
  assign bus.reg_data    = dly_data_q[WR_LAT-1];
  assign bus.shift_first = shift_first_q;
  assign bus.shift_last  = shift_last_q;
  assign bus.ovf         = ovf_q;

endmodule

// File: tb/tb_node_xfer_buf.sv
// Directed, scoreboard-checked bench for node_xfer_buf (default 8x8 lanes, DEPTH 16, WR_LAT 3).
module tb_node_xfer_buf;
  import node_xfer_buf_pkg::*;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned WR_LAT = 3;
  localparam logic [63:0] WA = 64'h0102030405060708;
  localparam logic [63:0] WB = 64'h1112131415161718;
`ifdef NODE_XFER_LANE_REV_EN
  localparam logic [63:0] WA_HOST = 64'h0807060504030201;
`else
  localparam logic [63:0] WA_HOST = 64'h0102030405060708;
`endif

  typedef struct {
    int          due;
    logic [63:0] data;
  } wr_exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int rv_cnt = 0;
  int sf_cnt = 0;
  int sl_cnt = 0;
  bit keep_push = 1'b0;

  wr_exp_t     wq[$];
  logic [63:0] rq[$];

  node_xfer_buf_if #(.DEPTH(DEPTH)) bus ();

  node_xfer_buf #(
    .DEPTH  (DEPTH),
    .WR_LAT (WR_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mask(input logic [63:0] w);
    return w & {8{8'h7F}};
  endfunction

  function automatic logic [63:0] host_order(input logic [63:0] w);
    logic [63:0] r;
`ifdef NODE_XFER_LANE_REV_EN
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = w[(7-i)*8 +: 8];
`else
    r = w;
`endif
    return mask(r);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: record what the DUT is about to accept, then check outputs #1 after the edge.
  task automatic step();
    logic        wacc;
    logic        exp_v;
    logic [63:0] wd;
    wacc = bus.wr_req && bus.ready && !reset;
    wd   = bus.wdata;
    if (bus.out_valid && keep_push && !reset) rq.push_back(host_order(bus.out_data));
    @(posedge clk);
    #1;
    cyc++;
    if (wacc) wq.push_back('{cyc + int'(WR_LAT) - 1, mask(wd)});
    exp_v = (wq.size() > 0) && (wq[0].due == cyc);
    check("reg_valid", bus.reg_valid, exp_v);
    if (exp_v) begin
      check("reg_data", bus.reg_data, wq[0].data);
      void'(wq.pop_front());
    end
    if (bus.rvalid) begin
      rv_cnt++;
      if (rq.size() == 0) check("rvalid_unexpected", bus.rvalid, 1'b0);
      else check("rdata", bus.rdata, rq.pop_front());
    end
    sf_cnt += int'(bus.shift_first);
    sl_cnt += int'(bus.shift_last);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int         acc;
    bit         bub;
    int         sf0, sl0, rv0;
    logic [7:0] b;

    bus.ord_num   = '0;
    bus.wr_req    = 1'b0;
    bus.wdata     = '0;
    bus.rd_req    = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;

    // Asynchronous reset before any clock edge
    #1 reset = 1'b1;
    #1;
    check("rst_ready", bus.ready, 1'b1);
    check("rst_flags", {bus.rvalid, bus.reg_valid, bus.shift_first, bus.shift_last, bus.ovf}, '0);
    check("rst_rdata", bus.rdata, '0);
    check("rst_reg_data", bus.reg_data, '0);
    step();
    step();
    reset = 1'b0;
    step();
    check("idle_ready", bus.ready, 1'b1);

    // Full frame of writes: 4 nodes x 4 beats of all-ones
    bus.ord_num = 4'd3;
    bus.wdata   = '1;
    bus.wr_req  = 1'b1;
    acc = 0;
    bub = 1'b0;
    sf0 = sf_cnt;
    sl0 = sl_cnt;
    for (int c = 0; c < 40 && acc < 16; c++) begin
      check("wr_ready", bus.ready, !bub);
      if (bus.ready) begin
        bub = (acc % 4 == 0);
        acc++;
      end else begin
        bub = 1'b0;
      end
      step();
      if (acc == 16) check("wr_shift_last_beat16", bus.shift_last, 1'b1);
    end
    bus.wr_req = 1'b0;
    check("wr_beats", acc, 16);
    for (int c = 0; c < 4; c++) step();
    check("wr_drained", wq.size(), 0);
    check("wr_shift_first_cnt", sf_cnt - sf0, 4);
    check("wr_shift_last_cnt", sl_cnt - sl0, 1);
    check("wr_idle_ready", bus.ready, 1'b1);

    // Read of one node, two beats
    bus.ord_num = 4'd1;
    sf0 = sf_cnt;
    sl0 = sl_cnt;
    rv0 = rv_cnt;
    keep_push = 1'b1;
    bus.rd_req = 1'b1;
    step();
    check("rd_wait_ready", bus.ready, 1'b0);
    bus.out_valid = 1'b1;
    bus.out_data  = WA;
    step();
    check("rd_ready", bus.ready, 1'b1);
    bus.out_data = WB;
    step();
    check("rd_lane_order", bus.rdata, WA_HOST);
    bus.out_valid = 1'b0;
    step();
    bus.rd_req = 1'b0;
    step();
    check("rd_idle_ready", bus.ready, 1'b1);
    check("rd_rvalid_cnt", rv_cnt - rv0, 2);
    check("rd_shift_first_cnt", sf_cnt - sf0, 1);
    check("rd_shift_last_cnt", sl_cnt - sl0, 0);
    check("rd_drained", rq.size(), 0);

    // Read with an empty FIFO stalls until the pipeline pushes
    rv0 = rv_cnt;
    bus.rd_req = 1'b1;
    step();
    for (int c = 0; c < 10; c++) begin
      check("empty_ready", bus.ready, 1'b0);
      check("empty_rvalid", bus.rvalid, 1'b0);
      step();
    end
    bus.out_valid = 1'b1;
    bus.out_data  = WB;
    step();
    bus.out_valid = 1'b0;
    check("first_push_ready", bus.ready, 1'b1);
    step();
    check("drained_ready", bus.ready, 1'b0);
    bus.out_valid = 1'b1;
    bus.out_data  = WA;
    step();
    bus.out_valid = 1'b0;
    step();
    bus.rd_req = 1'b0;
    step();
    check("empty_rvalid_cnt", rv_cnt - rv0, 2);
    check("empty_drained", rq.size(), 0);

    // Overflow: DEPTH+2 pushes with no reads, then read DEPTH back
    bus.ord_num = 4'd15;
    rv0 = rv_cnt;
    bus.rd_req = 1'b1;
    step();
    bus.rd_req = 1'b0;
    check("ovf_clear_before", bus.ovf, 1'b0);
    bus.out_valid = 1'b1;
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin
      keep_push = (i < int'(DEPTH));
      b = 8'(i + 1);
      bus.out_data = {8{b}};
      step();
    end
    bus.out_valid = 1'b0;
    keep_push = 1'b1;
    check("ovf_set", bus.ovf, 1'b1);
    bus.rd_req = 1'b1;
    for (int i = 0; i < int'(DEPTH); i++) step();
    bus.rd_req = 1'b0;
    step();
    check("ovf_rvalid_cnt", rv_cnt - rv0, int'(DEPTH));
    check("ovf_drained", rq.size(), 0);
    check("ovf_sticky", bus.ovf, 1'b1);
    check("ovf_idle_ready", bus.ready, 1'b1);

    // Simultaneous write and read in IDLE: write wins
    bus.ord_num = 4'd1;
    bus.wdata   = 64'h8123456789ABCDEF;
    bus.wr_req  = 1'b1;
    bus.rd_req  = 1'b1;
    check("coll_ready", bus.ready, 1'b1);
    step();
    check("coll_bubble", bus.ready, 1'b0);
    step();
    check("coll_in_wr", bus.ready, 1'b1);
    step();
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    for (int c = 0; c < 4; c++) step();
    check("coll_drained", wq.size(), 0);
    check("coll_idle_ready", bus.ready, 1'b1);

    // Reset in the middle of a node
    bus.ord_num = 4'd3;
    bus.wdata   = WB;
    bus.wr_req  = 1'b1;
    step();
    step();
    step();
    check("mid_reg_valid_pre", bus.reg_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_ready", bus.ready, 1'b1);
    check("mid_rst_flags", {bus.rvalid, bus.reg_valid, bus.shift_first, bus.shift_last, bus.ovf},
          '0);
    check("mid_rst_reg_data", bus.reg_data, '0);
    wq.delete();
    rq.delete();
    bus.wr_req = 1'b0;
    step();
    reset = 1'b0;
    step();
    check("post_rst_ready", bus.ready, 1'b1);

    // Counters restart at zero: a single ord_num=0 beat raises shift_first
    bus.ord_num = 4'd0;
    bus.wdata   = WA;
    bus.wr_req  = 1'b1;
    step();
    bus.wr_req = 1'b0;
    check("post_rst_shift_first", bus.shift_first, 1'b1);
    for (int c = 0; c < 4; c++) step();
    check("post_rst_drained", wq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/node_xfer_buf.md
Name: node_xfer_buf

Overview:
- Parametrised successor of the per-node ordering staging register.
- Moves replica ordering words between the host bus and the replica pipeline, in both directions.
- Host-write beats are lane-masked, delayed a fixed number of cycles and forwarded to the pipeline.
- Pipeline output words are captured into a FIFO and drained by host reads. Beat and node counters raise exchange-shift strobes at node and frame boundaries.

Parameters:
- LANES, 8, byte lanes per word
- LANE_W, 8, bits per lane; the top bit of each lane is a flag bit and is forced to 0
- DEPTH, 16, read FIFO entries (power of 2)
- NODE_NUM, 4, nodes per frame
- WR_LAT, 3, host-write to reg_valid latency in cycles (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- ord_num  in  $clog2(DEPTH)  beats per node minus 1
- wr_req  in  1  host write beat request
- wdata  in  LANES*LANE_W  host write word
- rd_req  in  1  host read beat request
- out_valid  in  1  pipeline word valid
- out_data  in  LANES*LANE_W  pipeline word
- ready  out  1  beat accepted this cycle if its request is high
- rvalid  out  1  rdata valid
- rdata  out  LANES*LANE_W  host read word
- reg_valid  out  1  forwarded write valid
- reg_data  out  LANES*LANE_W  forwarded write word
- shift_first  out  1  registered pulse: first beat of a node accepted
- shift_last  out  1  registered pulse: last beat of the last node accepted
- ovf  out  1  sticky FIFO overflow flag

Behaviour:
- Reset: clk and reset only; reset is asynchronous, active-high. All outputs 0 except ready=1. Counters, FIFO pointers and the write delay line clear to 0. State = IDLE.
- FSM states: IDLE, WR (node transfer host->pipe), RD_WAIT, RD (node transfer pipe->host).
  - IDLE->WR on an accepted wr_req.
  - IDLE->RD_WAIT on rd_req. The FIFO is flushed on entry; ready=0 while in RD_WAIT.
  - RD_WAIT->RD when the FIFO is non-empty.
  - WR or RD->IDLE after the beat with cnt==ord_num.
- Request priority: wr_req and rd_req high together in IDLE → the write wins; rd_req is ignored that cycle.
- Accept rule: beat accepted = req && ready.
  - In WR, ready=1 for every beat except the cycle after the cnt==0 beat. That one bubble gives the pipeline time to shift.
  - In RD, ready = FIFO non-empty.
- Counters:
  - cnt increments per accepted beat and wraps to 0 after ord_num.
  - node increments when cnt wraps, and wraps 0 after NODE_NUM-1.
- Strobes:
  - shift_first=1 the cycle after the beat with cnt==0.
  - shift_last=1 the cycle after the beat with cnt==ord_num and node==NODE_NUM-1.
  - The two pulse together when ord_num==0 on the last node.
- Write path:
  - Each lane has bit LANE_W-1 cleared.
  - The word travels WR_LAT register stages and appears as reg_valid/reg_data exactly WR_LAT cycles after acceptance.
  - Stages do not stall; bubbles propagate as reg_valid=0.
- Read path:
  - FIFO pushes on out_valid; pops on an accepted read beat.
  - rvalid/rdata are registered, 1 cycle after acceptance; lane bit LANE_W-1 of rdata is 0.
  - Push and pop in the same cycle: both occur and the count is unchanged.
  - Push when full: word dropped, ovf set. ovf clears only on reset.
- Reset mid-transfer: everything aborts immediately. No strobe or rvalid is emitted for the partial beat.

Optional Feature:
- Macro NODE_XFER_LANE_REV_EN.
  - Defined: rdata lane i = FIFO word lane LANES-1-i, for host byte-order compatibility.
  - Undefined: lane order is preserved.
- The write path is unaffected either way.

Decomposition:
- Shared package:
  - constants LANES, LANE_W, NODE_NUM
  - typedef ord_word_t (LANES x LANE_W packed array)
  - enum xfer_state_t {IDLE, WR, RD_WAIT, RD}
- Sub-module node_xfer_fifo: synchronous FIFO of DEPTH, with flush, full/empty, and drop-on-full with an overflow pulse.

Test Plan:
- Write, ord_num=3, NODE_NUM=4, 16 beats with wdata=0xFF repeated → each reg_data lane is 0x7F, reg_valid exactly WR_LAT=3 cycles after each accept. ready=0 on the cycle after each cnt==0 beat; shift_first pulses 4 times; shift_last pulses once, after beat 16.
- Read, ord_num=1: push 2 words 0x0102030405060708 and 0x1112131415161718, then rd_req held → RD_WAIT→RD, two rvalid pulses in push order, shift_first once, FSM returns to IDLE.
- Empty read: rd_req with no out_valid for 10 cycles → ready=0, rvalid=0 throughout. First push → ready=1 on the next cycle.
- Overflow: DEPTH+2 pushes without a read → ovf=1, and the first DEPTH words read back unchanged.
- wr_req and rd_req together in IDLE → WR entered, no FIFO flush. Assert reset mid-node → all outputs at reset values in the same cycle, ready=1.
- NODE_XFER_LANE_REV_EN defined, push 0x0102030405060708 → rdata=0x0807060504030201. Undefined → 0x0102030405060708.
